// File: rtl/regfile_alu_wb_if.sv
// Bundles the register-file/ALU/write-back datapath signals between decode and execute.
// Latency: carries only combinational datapath signals; this interface has no state.
// Backpressure: none; decode drives operands every cycle and the datapath always accepts them.
interface regfile_alu_wb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int KEY_LEN    = 3
);
  logic                  wen;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [KEY_LEN-1:0]    wsel;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [DATA_WIDTH-1:0] link_data;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [ADDR_WIDTH-1:0] raddr3;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic [DATA_WIDTH-1:0] rdata3;
  logic [DATA_WIDTH-1:0] alu_sum;
  logic [DATA_WIDTH-1:0] wdata;

  // Decode side: drives indices, operands and the write-back key.
  modport master (
    output wen, waddr, wsel, alu_a, alu_b, ext_data, link_data,
    output raddr1, raddr2, raddr3,
    input  rdata1, rdata2, rdata3, alu_sum, wdata
  );

  // Datapath side: returns read data, the sum and the selected write-back value.
  modport slave (
    input  wen, waddr, wsel, alu_a, alu_b, ext_data, link_data,
    input  raddr1, raddr2, raddr3,
    output rdata1, rdata2, rdata3, alu_sum, wdata
  );
endinterface

// File: rtl/regfile_alu_wb.sv
// RV64 register file (3R/1W, x0 = 0), 64-bit adder and key-matched write-back mux; DBG_REGS_EN adds dbg_regs.
// Latency: reads, sum and wdata are combinational; a write lands on the next rising edge (no bypass).
// Backpressure: none; a write is accepted on every edge with wen=1 and waddr!=0.
module regfile_alu_wb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int KEY_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_alu_wb_if.slave      bus
`ifdef DBG_REGS_EN
  ,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] dbg_regs
`endif
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  localparam logic [KEY_LEN-1:0] KEY_ALU  = KEY_LEN'(0);
  localparam logic [KEY_LEN-1:0] KEY_EXT  = KEY_LEN'(1);
  localparam logic [KEY_LEN-1:0] KEY_LINK = KEY_LEN'(2);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] wb_val;

  // Wrapping adder; the carry out is intentionally dropped.
  assign sum         = bus.alu_a + bus.alu_b;
  assign bus.alu_sum = sum;

  // Write-back source mux; unknown or unmapped keys fall through to zero rather than propagating X.
  always_comb begin
    wb_val = '0;
    case (bus.wsel)
      KEY_ALU:  wb_val = sum;
      KEY_EXT:  wb_val = bus.ext_data;
      KEY_LINK: wb_val = bus.link_data;
      default:  wb_val = '0;
    endcase
  end

  assign bus.wdata = wb_val;

  // Register state: reset wins over a same-edge write, and writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wen && (bus.waddr != '0)) begin
      regs[bus.waddr] <= wb_val;
    end
  end

  // Read ports force x0 to zero so entry 0 never depends on having seen a reset.
  assign bus.rdata1 = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
  assign bus.rdata2 = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];
  assign bus.rdata3 = (bus.raddr3 == '0) ? '0 : regs[bus.raddr3];

`ifdef DBG_REGS_EN
  // Flat mirror of the live registers for the simulator GPR dump.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
    if (g == 0) begin : g_zero
      assign dbg_regs[g*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_live
      assign dbg_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  end
`endif

endmodule

// File: tb/tb_regfile_alu_wb.sv
// Self-checking bench for regfile_alu_wb: reference model plus write scoreboard.
// Latency: expects combinational reads/wdata and writes visible after the next rising edge.
// Backpressure: none; stimulus is driven on the falling edge, outputs sampled 1 time unit later.
module tb_regfile_alu_wb;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int KL = 3;
  localparam int NR = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_alu_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEY_LEN(KL)) bus ();

`ifdef DBG_REGS_EN
  logic [NR*DW-1:0] dbg_regs;
  regfile_alu_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEY_LEN(KL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_regs(dbg_regs)
  );
`else
  regfile_alu_wb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEY_LEN(KL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model [NR];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb_q[$];

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_wb(input logic [KL-1:0] sel, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] ext,
                                           input logic [DW-1:0] link);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return ext;
      3'd2:    return link;
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic en, input logic [AW-1:0] addr, input logic [KL-1:0] sel,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] ext, input logic [DW-1:0] link);
    bus.wen       = en;
    bus.waddr     = addr;
    bus.wsel      = sel;
    bus.alu_a     = a;
    bus.alu_b     = b;
    bus.ext_data  = ext;
    bus.link_data = link;
  endtask

  // Checks wdata, queues the expected post-edge content of waddr, clocks, then pops and reads it back.
  task automatic commit();
    logic [DW-1:0] wb;
    logic [DW-1:0] exp;
    wr_exp_t       e;
    wr_exp_t       got;
    #1;
    wb = ref_wb(bus.wsel, bus.alu_a, bus.alu_b, bus.ext_data, bus.link_data);
    check("wdata_pre_edge", bus.wdata, wb);
    if (!rst_n || bus.waddr == '0) exp = '0;
    else if (bus.wen)               exp = wb;
    else                            exp = model[bus.waddr];
    e.addr = bus.waddr;
    e.data = exp;
    sb_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (bus.wen && bus.waddr != '0) begin
      model[bus.waddr] = wb;
    end
    @(negedge clk);
    bus.wen = 1'b0;
    got = sb_q.pop_front();
    bus.raddr3 = got.addr;
    #1;
    check("sb_readback", bus.rdata3, got.data);
  endtask

  initial begin
    logic [DW-1:0] a, b, ext, link;
    logic [AW-1:0] addr;
    logic [KL-1:0] sel;
    logic          en;

    for (int i = 0; i < NR; i++) model[i] = '0;
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    bus.raddr3 = '0;
    drive(1'b0, '0, '0, '0, '0, '0, '0);

    // Reset with a competing write pending.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 3'd1, '0, '0, 64'h55, '0);
    commit();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) begin
      bus.raddr1 = AW'(i);
      bus.raddr2 = AW'((i + 1) % NR);
      bus.raddr3 = AW'((i + 2) % NR);
      #1;
      check("reset_rd1", bus.rdata1, '0);
      check("reset_rd2", bus.rdata2, '0);
      check("reset_rd3", bus.rdata3, '0);
    end

    // Plain ext_data write to x5.
    @(negedge clk);
    drive(1'b1, 5'd5, 3'd1, '0, '0, 64'hDEAD_BEEF_0000_1234, '0);
    commit();
    bus.raddr1 = 5'd5;
    #1;
    check("x5_rd1", bus.rdata1, 64'hDEAD_BEEF_0000_1234);

    // x0 ignores writes.
    @(negedge clk);
    drive(1'b1, 5'd0, 3'd1, '0, '0, 64'h1, '0);
    commit();
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    #1;
    check("x0_rd1", bus.rdata1, '0);
    check("x0_rd2", bus.rdata2, '0);

    // Adder wraps; write the sum to x3.
    @(negedge clk);
    drive(1'b1, 5'd3, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hAAAA, 64'hBBBB);
    #1;
    check("alu_wrap", bus.alu_sum, 64'd1);
    commit();
    bus.raddr2 = 5'd3;
    #1;
    check("x3_rd2", bus.rdata2, 64'd1);

    // Selector: link key and all unmapped keys.
    drive(1'b0, 5'd4, 3'd2, 64'h10, 64'h20, 64'h1234, 64'h8000_0004);
    #1;
    check("sel_link", bus.wdata, 64'h8000_0004);
    for (int s = 3; s < 8; s++) begin
      bus.wsel = KL'(s);
      #1;
      check("sel_default", bus.wdata, '0);
    end
    bus.wsel = 3'd0;
    #1;
    check("sel_alu", bus.wdata, 64'h30);
    bus.wsel = 3'd1;
    #1;
    check("sel_ext", bus.wdata, 64'h1234);

    // Read-during-write returns the old value, then reset beats a same-edge write.
    @(negedge clk);
    drive(1'b1, 5'd7, 3'd1, '0, '0, 64'd9, '0);
    commit();
    drive(1'b1, 5'd7, 3'd1, '0, '0, 64'd5, '0);
    bus.raddr2 = 5'd7;
    #1;
    check("rdw_old", bus.rdata2, 64'd9);
    commit();
    check("rdw_new", bus.rdata2, 64'd5);
    drive(1'b1, 5'd7, 3'd1, '0, '0, 64'd5, '0);
    rst_n = 1'b0;
    commit();
    rst_n = 1'b1;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd3;
    #1;
    check("rst_clr_x5", bus.rdata1, '0);
    check("rst_clr_x3", bus.rdata2, '0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      en   = ($urandom_range(0, 3) != 0);
      addr = AW'($urandom_range(0, NR - 1));
      sel  = KL'($urandom_range(0, 4));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      ext  = {$urandom, $urandom};
      link = {$urandom, $urandom};
      drive(en, addr, sel, a, b, ext, link);
      bus.raddr1 = AW'($urandom_range(0, NR - 1));
      bus.raddr2 = (n % 4 == 0) ? addr : AW'($urandom_range(0, NR - 1));
      #1;
      check("rnd_sum", bus.alu_sum, a + b);
      check("rnd_rd1", bus.rdata1, model[bus.raddr1]);
      check("rnd_rd2", bus.rdata2, model[bus.raddr2]);
      commit();
    end

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
